// File: rtl/tinker_mem_arbiter.sv
// Memory-port arbiter for the multicycle Tinker core: round-robin between
// instruction fetch and data load/store, one outstanding transaction, with a
// response watchdog.
module tinker_mem_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // data load/store requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory port
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              busy,
  output logic              owner,
  output logic              err_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam bit          LP_WD_EN   = (TIMEOUT != 0);
  localparam logic [31:0] LP_WD_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic        r_last_d;
  logic [31:0] r_wd_cnt;

  logic w_any_req;
  logic w_pick_d;
  logic w_grant;
  logic w_accept;
  logic w_rsp;
  logic w_expire;
  logic w_done;

  assign w_any_req = if_req | d_req;
  // Data wins when alone, or on a tie when fetch was granted last.
  assign w_pick_d  = d_req & (~if_req | ~r_last_d);
  assign w_grant   = (r_state == S_IDLE) & w_any_req;
  assign w_accept  = (r_state == S_ISSUE) & mem_ready;
  assign w_rsp     = (r_state == S_WAIT) & mem_rvalid;
  // mem_rvalid takes priority over a watchdog expiry in the same cycle.
  assign w_expire  = LP_WD_EN & (r_state == S_WAIT) & ~mem_rvalid &
                     (r_wd_cnt == LP_WD_LAST);
  assign w_done    = w_rsp | w_expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_state <= S_ISSUE;
          busy    <= 1'b1;
        end
        S_ISSUE: if (w_accept) r_state <= S_WAIT;
        S_WAIT:  if (w_done)   r_state <= S_RESP;
        S_RESP: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_d <= 1'b1;
      owner    <= 1'b0;
      if_gnt   <= 1'b0;
      d_gnt    <= 1'b0;
    end else begin
      if_gnt <= 1'b0;
      d_gnt  <= 1'b0;
      if (w_grant) begin
        r_last_d <= w_pick_d;
        owner    <= w_pick_d;
        if_gnt   <= ~w_pick_d;
        d_gnt    <= w_pick_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (w_grant) begin
      mem_valid <= 1'b1;
      mem_we    <= w_pick_d & d_we;
      mem_addr  <= w_pick_d ? d_addr : if_addr;
      mem_wdata <= w_pick_d ? d_wdata : '0;
    end else if (w_accept) begin
      mem_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt <= '0;
    end else if (w_accept) begin
      r_wd_cnt <= '0;
    end else if ((r_state == S_WAIT) && !w_done) begin
      r_wd_cnt <= r_wd_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_rvalid   <= 1'b0;
      d_rvalid    <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (w_done) begin
        if_rvalid <= ~owner;
        d_rvalid  <= owner;
        if (!owner) begin
          if_rdata <= w_rsp ? mem_rdata[31:0] : '0;
        end else if (!mem_we) begin
          d_rdata <= w_rsp ? mem_rdata : '0;
        end
        if (w_expire) err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Randomized scoreboard bench for tinker_mem_arbiter: a stimulus process predicts
// each transaction from the arbitration rules, a monitor compares DUT responses.
module tb_tinker_mem_arbiter;

  logic        clk, reset;
  logic        if_req, d_req, d_we;
  logic [63:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata;
  logic [63:0] d_rdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, owner, err_timeout;

  tinker_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          who;      // 0 fetch, 1 data
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int unsigned rdy;
    int unsigned dly;
    bit          tmo;
    bit          err;
    int unsigned lat;
    bit          b2b;
    bit          granted;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] mm   [logic [63:0]];   // scoreboard view of memory
  logic [63:0] phys [logic [63:0]];   // responder's memory array
  int unsigned n_cmp = 0, n_fail = 0;
  bit          m_last_d = 1'b1, m_err = 1'b0, pend_if = 1'b0, pend_d = 1'b0;
  logic [63:0] m_d_rdata = '0;

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
  endfunction

  function automatic logic [63:0] rd(input logic [63:0] a);
    return mm.exists(a) ? mm[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_if_gnt"}, if_gnt, 0);       chk({tag, "_if_rvalid"}, if_rvalid, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);   chk({tag, "_d_gnt"}, d_gnt, 0);
    chk({tag, "_d_rvalid"}, d_rvalid, 0);   chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_mem_valid"}, mem_valid, 0); chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);   chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);           chk({tag, "_owner"}, owner, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  task automatic issue_if(input logic [63:0] a);
    if_addr = a; if_req = 1'b1; pend_if = 1'b1;
  endtask

  task automatic issue_d(input bit we, input logic [63:0] a, input logic [63:0] w);
    d_we = we; d_addr = a; d_wdata = w; d_req = 1'b1; pend_d = 1'b1;
  endtask

  // Predict the next grant from the pending requests and queue its expectation.
  task automatic predict(input int unsigned rdy, input int unsigned dly,
                         input bit tmo, input bit b2b);
    exp_t e;
    logic [63:0] v;
    e.who = (pend_if && pend_d) ? !m_last_d : pend_d;
    m_last_d = e.who;
    e.we    = e.who ? d_we : 1'b0;
    e.addr  = e.who ? d_addr : if_addr;
    e.wdata = d_wdata;
    v = rd(e.addr);
    if (!e.who) begin
      e.rdata = tmo ? 64'h0 : {32'h0, v[31:0]};
    end else if (!e.we) begin
      e.rdata = tmo ? 64'h0 : v;
      m_d_rdata = e.rdata;
    end else begin
      mm[e.addr] = e.wdata;
      e.rdata = m_d_rdata;
    end
    if (tmo) m_err = 1'b1;
    e.err = m_err; e.rdy = rdy; e.dly = dly; e.tmo = tmo;
    e.lat = tmo ? 5 : dly + 2;
    e.b2b = b2b; e.granted = 1'b0;
    sbq.push_back(e);
  endtask

  task automatic wait_gnt();
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); #2;
      if (if_gnt) begin if_req = 1'b0; pend_if = 1'b0; got = 1'b1; end
      if (d_gnt)  begin d_req  = 1'b0; pend_d  = 1'b0; got = 1'b1; end
    end
    if (!got) chk("gnt_wait_expired", 0, 1);
  endtask

  task automatic wait_rvalid();
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk); #2;
      if (if_rvalid || d_rvalid) got = 1'b1;
    end
    if (!got) chk("rvalid_wait_expired", 0, 1);
  endtask

  task automatic do_round(input int unsigned rdy, input int unsigned dly,
                          input bit tmo, input bit b2b);
    if (!pend_if && !pend_d) return;
    predict(rdy, dly, tmo, b2b);
    wait_gnt();
    wait_rvalid();
  endtask

  function automatic logic [63:0] rand_addr();
    if ($urandom % 5 == 0) return {$urandom, $urandom};
    return 64'h1000 + 64'(8 * ($urandom % 8));
  endfunction

  // Memory responder: ready after rdy cycles, response in WAIT cycle dly+1,
  // never for watchdog cases; junk handshakes whenever they must be ignored.
  initial begin
    int unsigned ph = 0, cnt = 0, w = 0;
    logic [63:0] la = '0;
    bit stale = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
      if (reset) begin ph = 0; stale = 1'b1; continue; end
      if (stale) begin mem_rvalid = 1'b1; stale = 1'b0; continue; end
      if (ph == 0 && mem_valid && sbq.size() > 0) begin cnt = sbq[0].rdy; ph = 1; end
      if (ph == 1) begin
        mem_rvalid = ($urandom % 4 == 0);
        if (cnt == 0) begin
          mem_ready = 1'b1; ph = 2; w = 0; la = mem_addr;
          if (mem_we) phys[mem_addr] = mem_wdata;
        end else cnt--;
      end else if (ph == 2) begin
        w++;
        if (sbq.size() == 0) ph = 0;
        else if (!sbq[0].tmo && w == sbq[0].dly + 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = phys.exists(la) ? phys[la] : init_val(la);
          ph = 0;
        end else if (sbq[0].tmo && w == 4) ph = 0;
      end else begin
        mem_rvalid = ($urandom % 6 == 0);
        if (!mem_valid) mem_ready = ($urandom % 5 == 0);
      end
    end
  end

  // Monitor: compares DUT activity against the head of the scoreboard.
  initial begin
    exp_t e;
    int unsigned lat = 0, since_rv = 1000;
    bit acc = 1'b0, idle_chk = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin acc = 1'b0; idle_chk = 1'b0; since_rv = 1000; continue; end
      since_rv++;
      if (acc) begin lat++; chk("mem_valid_after_accept", mem_valid, 0); end
      if (idle_chk) begin
        chk("idle_busy", busy, 0); chk("idle_mem_valid", mem_valid, 0);
        idle_chk = 1'b0;
      end
      if (if_gnt || d_gnt) begin
        if (sbq.size() == 0) chk("gnt_unexpected", 1, 0);
        else begin
          chk("gnt_who", d_gnt, sbq[0].who);
          chk("gnt_onehot", if_gnt & d_gnt, 0);
          chk("gnt_repeat", sbq[0].granted, 0);
          sbq[0].granted = 1'b1;
          chk("owner", owner, sbq[0].who);
          chk("busy_issue", busy, 1);
          if (sbq[0].b2b) chk("turnaround", since_rv, 2);
        end
      end
      if (mem_valid && sbq.size() > 0) begin
        chk("mem_addr", mem_addr, sbq[0].addr);
        chk("mem_we", mem_we, sbq[0].we);
        if (sbq[0].we) chk("mem_wdata", mem_wdata, sbq[0].wdata);
      end
      if (mem_valid && mem_ready) begin acc = 1'b1; lat = 0; end
      if (if_rvalid || d_rvalid) begin
        if (sbq.size() == 0) chk("rvalid_unexpected", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("rv_who", d_rvalid, e.who);
          chk("rv_onehot", if_rvalid & d_rvalid, 0);
          chk("rdata", e.who ? d_rdata : {32'h0, if_rdata}, e.rdata);
          chk("err_timeout", err_timeout, e.err);
          chk("latency", acc ? lat : 999, e.lat);
          chk("busy_resp", busy, 1);
        end
        acc = 1'b0; idle_chk = 1'b1; since_rv = 0;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL global_time_limit: got running, expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    bit gap;
    int unsigned r;
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    @(negedge clk); #2;
    check_all_zero("reset");
    @(negedge clk); reset = 1'b0;

    // directed: store, fetch of the stored word, store/load, backpressure, watchdog
    issue_d(1'b1, 64'h2000, 64'hDEADBEEF_C0DE1234); do_round(0, 0, 1'b0, 1'b0);
    issue_if(64'h2000);                              do_round(0, 0, 1'b0, 1'b1);
    issue_d(1'b1, 64'h7FFF8, 64'h1122334455667788); do_round(1, 1, 1'b0, 1'b1);
    issue_d(1'b0, 64'h7FFF8, 64'h0);                 do_round(0, 2, 1'b0, 1'b1);
    issue_if(64'h3000);                              do_round(5, 0, 1'b0, 1'b1);
    issue_if(64'h2000);                              do_round(0, 0, 1'b1, 1'b1);
    issue_d(1'b0, 64'h2000, 64'h0);                  do_round(0, 3, 1'b0, 1'b1);

    // contention: both held high, grants must alternate
    for (int k = 0; k < 4; k++) begin
      if (!pend_if) issue_if(rand_addr());
      if (!pend_d)  issue_d($urandom % 2, rand_addr(), {$urandom, $urandom});
      do_round($urandom % 3, $urandom % 3, 1'b0, 1'b1);
    end

    for (int n = 0; n < 150; n++) begin
      gap = 1'b0;
      if (!pend_if && !pend_d && ($urandom % 4 == 0)) begin
        gap = 1'b1;
        repeat (1 + $urandom % 3) @(negedge clk);
        #2;
      end
      r = $urandom % 3;
      if ((r == 0 || r == 2) && !pend_if) issue_if(rand_addr());
      if ((r == 1 || r == 2) && !pend_d)  issue_d($urandom % 2, rand_addr(), {$urandom, $urandom});
      do_round($urandom % 4, $urandom % 4, ($urandom % 12 == 0), !gap);
    end
    while (pend_if || pend_d) do_round(0, 1, 1'b0, 1'b1);

    // reset in the middle of WAIT
    issue_if(64'h4000);
    predict(0, 0, 1'b1, 1'b0);
    wait_gnt();
    @(negedge clk); @(negedge clk); #5;
    reset = 1'b1;
    #1;
    check_all_zero("midwait");
    sbq.delete();
    m_last_d = 1'b1; m_err = 1'b0; m_d_rdata = '0;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    issue_if(64'h5000);
    issue_d(1'b0, 64'h1008, 64'h0);
    do_round(0, 0, 1'b0, 1'b0);
    do_round(1, 1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
